// File: rtl/kogge_stone_32bit.sv
// Registered WIDTH-bit adder with carry-in/carry-out; carries come from a
// radix-2 Kogge-Stone prefix tree feeding a single output register stage.
module kogge_stone_32bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  localparam int LEVELS = $clog2(WIDTH);

  logic [WIDTH-1:0] p_p0;
  logic [WIDTH-1:0] g_lvl [0:LEVELS];
  logic [WIDTH-1:0] p_lvl [0:LEVELS];
  logic [WIDTH-1:0] carry_p0;
  logic [WIDTH-1:0] sum_p0;
  logic             cout_p0;

  // Stage 0: bitwise propagate/generate, prefix tree and sum, all combinational.
  // Cin is folded into bit 0's generate so every group generate already includes it.
  always_comb begin
    p_p0     = A ^ B;
    g_lvl[0] = A & B;
    g_lvl[0][0] = (A[0] & B[0]) | (p_p0[0] & Cin);
    p_lvl[0] = p_p0;
    for (int k = 0; k < LEVELS; k++) begin
      g_lvl[k+1] = g_lvl[k];
      p_lvl[k+1] = p_lvl[k];
      for (int i = (1 << k); i < WIDTH; i++) begin
        g_lvl[k+1][i] = g_lvl[k][i] | (p_lvl[k][i] & g_lvl[k][i-(1<<k)]);
        p_lvl[k+1][i] = p_lvl[k][i] & p_lvl[k][i-(1<<k)];
      end
    end
    carry_p0 = {g_lvl[LEVELS][WIDTH-2:0], Cin};
    sum_p0   = p_p0 ^ carry_p0;
    cout_p0  = g_lvl[LEVELS][WIDTH-1];
  end

  // Stage 0 -> output register; reset wins over the operands sampled at the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      S    <= '0;
      Cout <= 1'b0;
    end else begin
      S    <= sum_p0;
      Cout <= cout_p0;
    end
  end

endmodule

// File: tb/tb_kogge_stone_32bit.sv
// Directed and random checks of the registered Kogge-Stone adder against
// hand-computed sums and a plain integer reference.
module tb_kogge_stone_32bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] A, B;
  logic        Cin;
  logic [31:0] S;
  logic        Cout;

  int n_checks = 0;
  int n_fail   = 0;

  kogge_stone_32bit #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .S    (S),
    .Cout (Cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one operand set, advance one edge, then compare {Cout,S}.
  task automatic apply(input string tag, input logic r, input logic [31:0] a,
                       input logic [31:0] b, input logic c,
                       input logic [31:0] exp_s, input logic exp_c);
    rst_n = r;
    A     = a;
    B     = b;
    Cin   = c;
    @(posedge clk);
    #1;
    check(tag, {31'b0, Cout, S}, {31'b0, exp_c, exp_s});
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rc, rr;
    logic [32:0] ref_sum;

    // Reset held for two edges with carry-generating operands.
    apply("reset_edge1", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0, 1'b0);
    apply("reset_edge2", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0, 1'b0);
    apply("reset_release", 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0001, 1'b1);

    // Outputs hold between edges.
    #4;
    check("hold_mid_cycle", {31'b0, Cout, S}, {31'b0, 1'b1, 32'h0000_0001});

    apply("full_propagate", 1'b1, 32'hFFFF_0000, 32'h0000_FFFF, 1'b1, 32'h0000_0000, 1'b1);
    apply("decimal_mid",    1'b1, 32'd2017701177, 32'd1701853, 1'b0, 32'h785D_A516, 1'b0);
    apply("both_carries",   1'b1, 32'hFFAB_CEDC, 32'hEF82_1EDA, 1'b1, 32'hEF2D_EDB7, 1'b1);
    apply("alt_propagate",  1'b1, 32'h5555_5555, 32'hAAAA_AAAA, 1'b1, 32'h0000_0000, 1'b1);
    apply("sign_wrap",      1'b1, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0);
    apply("all_zero",       1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0);
    apply("cin_only",       1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0);
    apply("max_plus_max",   1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1);
    apply("msb_overflow",   1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1);
    apply("mid_reset",      1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h0000_0000, 1'b0);
    apply("after_reset",    1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0);

    // Random regression with occasional reset pulses.
    for (int n = 0; n < 10000; n++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 63) != 0);
      ref_sum = {1'b0, ra} + {1'b0, rb} + {32'b0, rc};
      if (!rr) ref_sum = '0;
      apply("random", rr, ra, rb, rc, ref_sum[31:0], ref_sum[32]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
